serial_adder_ctrl: RTL

//   Bit-serial N-bit adder controller that time-shares a single adder_1bit full-adder cell.

---
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell processes a single operand bit per clock, LSB first.
// The result appears on sum/overflow with a one-cycle done pulse.

module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);
    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic                c_reg;
    logic [CW-1:0]       count;
    logic                s_bit, co_bit;
    logic                last;

    adder_1bit u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (c_reg),
        .s  (s_bit),
        .co (co_bit)
    );

    assign last    = (count == LAST);
    assign res_nxt = {s_bit, res_sr[NUM_BITS-1:1]};
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            c_reg    <= 1'b0;
            count    <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    assert (!$isunknown(start))
                        else $error("serial_adder_ctrl: start is X/Z");
                    if (start) begin
                        assert (!$isunknown({a, b, carry_in}))
                            else $error("serial_adder_ctrl: operand or carry_in is X/Z");
                        a_sr   <= a;
                        b_sr   <= b;
                        c_reg  <= carry_in;
                        count  <= '0;
                        res_sr <= '0;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    c_reg  <= co_bit;
                    count  <= count + 1'b1;
                    // Final bit: capture the completed result straight from the shift path.
                    if (last) begin
                        sum      <= res_nxt;
                        overflow <= co_bit;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
